instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter FQ_DEPTH, default 2: fetch-queue entries (legal values 2 or 4).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port imem_req  output  1  instruction-memory request valid.
REQ-006 SHALL have port imem_addr  output  32  word-aligned fetch address.
REQ-007 SHALL have port imem_gnt  input  1  memory accepts the request this cycle.
REQ-008 SHALL have port imem_rvalid  input  1  read data valid; arrives at least 1 cycle after its grant.
REQ-009 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-010 SHALL have port redirect_valid  input  1  branch/jump redirect from the datapath.
REQ-011 SHALL have port redirect_pc  input  32  redirect target.
REQ-012 SHALL have port instr_valid  output  1  instruction_word presented to DataPath.
REQ-013 SHALL have port instruction_word  output  32  instruction for DataPath.
REQ-014 SHALL have port instr_pc  output  32  PC of instruction_word.
REQ-015 SHALL have port instr_ready  input  1  DataPath consumes the instruction this cycle.
REQ-016 SHALL have port misalign_err  output  1  misaligned redirect flag (present only with IFU_MISALIGN_CHECK_EN).

Function
REQ-017 SHALL keep at most one outstanding memory request (granted, rvalid not yet seen).
REQ-018 SHALL assert imem_req only when queue occupancy plus outstanding count < FQ_DEPTH, and SHALL hold imem_addr stable until imem_gnt.
REQ-019 SHALL advance fetch PC by 4 on each grant; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-020 SHALL push {imem_rdata, request PC} into the queue on imem_rvalid in the RUN state.
REQ-021 SHALL drive instr_valid = queue not empty, with instruction_word/instr_pc from the head; pop on instr_valid && instr_ready.
REQ-022 SHALL hold head contents stable while instr_valid && !instr_ready.
REQ-023 SHALL accept simultaneous push and pop on a full queue without loss or overflow.
REQ-024 SHALL have FSM states RUN, WAIT (request granted, awaiting rvalid), FLUSH (discard one stale rvalid): RUN->WAIT on gnt; WAIT->RUN on rvalid; WAIT->FLUSH on redirect; FLUSH->RUN on rvalid.
REQ-025 SHALL, on redirect_valid, empty the queue, load fetch PC with {redirect_pc[31:2],2'b00} next cycle, and drop any grant or rvalid in the same cycle; redirect has priority over all other events.
REQ-026 SHALL deassert instr_valid the cycle after a redirect; minimum redirect-to-instr_valid latency 3 cycles (req/gnt, rvalid, queue output).
REQ-027 SHALL issue the new-target request in FLUSH state only after the stale rvalid is discarded.

Reset
REQ-028 SHALL, while rst is high at a clock edge: fetch PC <= RESET_PC, queue empty, state RUN, outstanding cleared, misalign_err <= 0.
REQ-029 SHALL drive imem_req = 0, instr_valid = 0, instruction_word = 0 and instr_pc = RESET_PC during the reset cycle; first request asserts the cycle after rst falls.
REQ-030 SHALL discard any rvalid arriving after reset for a request issued before reset.

Configuration
REQ-031 SHALL with IFU_MISALIGN_CHECK_EN defined: set misalign_err (sticky until rst) when redirect_valid && redirect_pc[1:0] != 0, and fetch nothing until reset.
REQ-032 SHALL without IFU_MISALIGN_CHECK_EN: omit misalign_err port; low address bits silently cleared.

Structure
REQ-033 SHALL place RESET_PC default, FSM state encoding and instruction width constant in shared package riscv_pkg.
REQ-034 SHALL implement the queue as sub-module fetch_queue (parameterised depth, push/pop/full/empty/flush).

Verification
REQ-035 Reset release, gnt always 1, rvalid 1 cycle later, ready=1 -> imem_addr 0,4,8...; instr_pc 0,4,8 back-to-back.
REQ-036 ready=0 for 10 cycles -> 2 entries held, imem_req low, instruction_word stable; release -> no word lost or duplicated.
REQ-037 Redirect to 32'h100 while request at 0x8 outstanding -> stale word dropped, next instr_pc = 0x100.
REQ-038 RESET_PC = 32'hFFFF_FFF8 -> instr_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 With macro, redirect_pc = 32'h102 -> misalign_err = 1 next cycle, imem_req stays 0 until rst.
REQ-040 rst asserted while WAIT -> next cycle imem_req = 0, instr_valid = 0; late rvalid ignored.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants: reset PC, FSM encoding, queue entry layout.
package riscv_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLUSH = 2'd2
  } ifu_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fq_entry_t;

  // Instruction fetches are always word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small register-based FIFO holding fetched {instruction, pc} entries.
// DEPTH must be a power of two (2 or 4) so the pointers wrap naturally.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [W-1:0]                 head_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (rst) begin
        mem_q[gi] <= '0;
      end else begin
        mem_q[gi] <= mem_d[gi];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requests feeding a small fetch queue.
// Optional feature macro IFU_MISALIGN_CHECK_EN adds a sticky misalign_err and halts fetch.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          FQ_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instruction_word,
  output logic [31:0]        instr_pc,
  input  logic               instr_ready
`ifdef IFU_MISALIGN_CHECK_EN
  ,
  output logic               misalign_err
`endif
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        fetch_halt;

  logic                            fq_push;
  logic                            fq_pop;
  logic                            fq_flush;
  logic                            fq_full;
  logic                            fq_empty;
  logic [$clog2(FQ_DEPTH+1)-1:0]   fq_count;
  fq_entry_t                       fq_in;
  fq_entry_t                       fq_head;
  logic                            outstanding;

`ifdef IFU_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign fetch_halt   = misalign_q;
  assign misalign_err = misalign_q;
`else
  assign fetch_halt = 1'b0;
`endif

  assign outstanding = (state_q != ST_RUN);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    fq_push  = 1'b0;
    fq_flush = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif
    // Suppressing the request during a redirect means no grant can be lost.
    imem_req = !rst && !redirect_valid && !fetch_halt && (state_q == ST_RUN) && !fq_full &&
               ((int'(fq_count) + (outstanding ? 1 : 0)) < FQ_DEPTH);

    if (redirect_valid) begin
      fq_flush = 1'b1;
      pc_d     = align_word(redirect_pc);
      // A stale response still in flight must be swallowed before refetching.
      state_d  = (outstanding && !imem_rvalid) ? ST_FLUSH : ST_RUN;
`ifdef IFU_MISALIGN_CHECK_EN
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
`endif
    end else begin
      case (state_q)
        ST_RUN: begin
          if (imem_req && imem_gnt) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            fq_push = 1'b1;
            state_d = ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (imem_rvalid) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

`ifdef IFU_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`endif

  assign fq_in.instr = imem_rdata;
  assign fq_in.pc    = req_pc_q;
  assign fq_pop      = instr_valid && instr_ready;

  fetch_queue #(
    .DEPTH (FQ_DEPTH),
    .W     ($bits(fq_entry_t))
  ) u_fetch_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (fq_flush),
    .push      (fq_push),
    .push_data (fq_in),
    .pop       (fq_pop),
    .head_data (fq_head),
    .full      (fq_full),
    .empty     (fq_empty),
    .count     (fq_count)
  );

  assign imem_addr        = pc_q;
  assign instr_valid      = !rst && !fq_empty;
  assign instruction_word = rst ? '0 : fq_head.instr;
  assign instr_pc         = rst ? RESET_PC : fq_head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; a second instance checks PC wrap from a high RESET_PC.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instruction_word, instr_pc;

  logic        imem_req_b, imem_gnt_b, imem_rvalid_b, instr_valid_b;
  logic [31:0] imem_addr_b, imem_rdata_b, instruction_word_b, instr_pc_b;
`ifdef IFU_MISALIGN_CHECK_EN
  logic        misalign_err, misalign_err_b;
`endif

  instr_fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instruction_word(instruction_word),
    .instr_pc(instr_pc), .instr_ready(instr_ready)
`ifdef IFU_MISALIGN_CHECK_EN
    , .misalign_err(misalign_err)
`endif
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk(clk), .rst(rst),
    .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_gnt(imem_gnt_b),
    .imem_rvalid(imem_rvalid_b), .imem_rdata(imem_rdata_b),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .instr_valid(instr_valid_b), .instruction_word(instruction_word_b),
    .instr_pc(instr_pc_b), .instr_ready(1'b1)
`ifdef IFU_MISALIGN_CHECK_EN
    , .misalign_err(misalign_err_b)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model state: one pending response per instance, returned a cycle after grant.
  logic        gnt_en, rv_hold;
  logic        pend_a, pend_b;
  logic [31:0] pend_addr_a, pend_addr_b;
  logic [31:0] grant_q[$], pop_pc_q[$], pop_word_q[$], pop_pc_b[$], pop_word_b[$];
  logic        obs_req, obs_valid, obs_mis;
  logic [31:0] obs_addr, obs_word, obs_pc, obs_pc_b;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One clock: drive memory responses at the negedge, observe, then advance.
  task automatic cycle();
    imem_rvalid   = pend_a && !rv_hold;
    imem_rdata    = ~pend_addr_a;
    imem_gnt      = gnt_en;
    imem_rvalid_b = pend_b;
    imem_rdata_b  = ~pend_addr_b;
    imem_gnt_b    = gnt_en;
    #1;
    obs_req   = imem_req;
    obs_addr  = imem_addr;
    obs_valid = instr_valid;
    obs_word  = instruction_word;
    obs_pc    = instr_pc;
    obs_pc_b  = instr_pc_b;
`ifdef IFU_MISALIGN_CHECK_EN
    obs_mis   = misalign_err;
`else
    obs_mis   = 1'b0;
`endif
    if (imem_rvalid) pend_a = 1'b0;
    if (imem_req && imem_gnt) begin
      pend_a      = 1'b1;
      pend_addr_a = imem_addr;
      grant_q.push_back(imem_addr);
    end
    if (imem_rvalid_b) pend_b = 1'b0;
    if (imem_req_b && imem_gnt_b) begin
      pend_b      = 1'b1;
      pend_addr_b = imem_addr_b;
    end
    if (instr_valid && instr_ready) begin
      pop_pc_q.push_back(instr_pc);
      pop_word_q.push_back(instruction_word);
      $display("[%0t] A pop pc=%08h word=%08h", $time, instr_pc, instruction_word);
    end
    if (instr_valid_b) begin
      pop_pc_b.push_back(instr_pc_b);
      pop_word_b.push_back(instruction_word_b);
      $display("[%0t] B pop pc=%08h word=%08h", $time, instr_pc_b, instruction_word_b);
    end
    @(negedge clk);
  endtask

  task automatic clear_logs();
    grant_q.delete();
    pop_pc_q.delete();
    pop_word_q.delete();
    pop_pc_b.delete();
    pop_word_b.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    instr_ready = 1'b1; gnt_en = 1'b1; rv_hold = 1'b0;
    cycle();
    cycle();
    pend_a = 1'b0;
    pend_b = 1'b0;
    rst = 1'b0;
    clear_logs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stable_errs;
    int reqs_seen;
    bit found;
    pend_a = 1'b0; pend_b = 1'b0; pend_addr_a = '0; pend_addr_b = '0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    instr_ready = 1'b1; gnt_en = 1'b1; rv_hold = 1'b0;

    // Reset-cycle outputs
    cycle();
    cycle();
    check_eq("rst_req",   32'(obs_req), 32'd0);
    check_eq("rst_valid", 32'(obs_valid), 32'd0);
    check_eq("rst_word",  obs_word, 32'h0);
    check_eq("rst_pc",    obs_pc, 32'h0);
    check_eq("rst_pc_b",  obs_pc_b, 32'hFFFF_FFF8);

    // Streaming fetch with gnt always high and ready high
    do_reset();
    cycle();
    check_eq("first_req",  32'(obs_req), 32'd1);
    check_eq("first_addr", obs_addr, 32'h0);
    repeat (11) cycle();
    check_eq("stream_grants", 32'(grant_q.size() >= 3), 32'd1);
    check_eq("stream_pops",   32'(pop_pc_q.size() >= 3), 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (i < grant_q.size()) check_eq($sformatf("stream_addr%0d", i), grant_q[i], 32'(4*i));
      if (i < pop_pc_q.size()) begin
        check_eq($sformatf("stream_pc%0d", i), pop_pc_q[i], 32'(4*i));
        check_eq($sformatf("stream_word%0d", i), pop_word_q[i], ~32'(4*i));
      end
    end

    // Back-pressure: ready low for 10 cycles
    do_reset();
    instr_ready = 1'b0;
    stable_errs = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (i >= 2 && obs_word !== ~32'h0) stable_errs++;
    end
    check_eq("stall_req",    32'(obs_req), 32'd0);
    check_eq("stall_valid",  32'(obs_valid), 32'd1);
    check_eq("stall_pc",     obs_pc, 32'h0);
    check_eq("stall_stable", 32'(stable_errs), 32'd0);
    instr_ready = 1'b1;
    repeat (10) cycle();
    check_eq("release_pops", 32'(pop_pc_q.size() >= 4), 32'd1);
    for (int i = 0; i < pop_pc_q.size(); i++) begin
      check_eq($sformatf("release_pc%0d", i), pop_pc_q[i], 32'(4*i));
      check_eq($sformatf("release_word%0d", i), pop_word_q[i], ~32'(4*i));
    end

    // Redirect while the fetch of 0x8 is outstanding, stale response delayed
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      found = pend_a && (pend_addr_a == 32'h8);
    end
    check_eq("redir_found8", 32'(found), 32'd1);
    clear_logs();
    redirect_valid = 1'b1; redirect_pc = 32'h100; rv_hold = 1'b1;
    cycle();
    redirect_valid = 1'b0; rv_hold = 1'b0;
    cycle();
    check_eq("flush_req",   32'(obs_req), 32'd0);
    check_eq("redir_valid", 32'(obs_valid), 32'd0);
    repeat (8) cycle();
    check_eq("redir_pops", 32'(pop_pc_q.size() >= 2), 32'd1);
    if (pop_pc_q.size() >= 2) begin
      check_eq("redir_pc0",   pop_pc_q[0], 32'h100);
      check_eq("redir_word0", pop_word_q[0], ~32'h100);
      check_eq("redir_pc1",   pop_pc_q[1], 32'h104);
    end

    // Misaligned redirect target
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    cycle();
    redirect_valid = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
    cycle();
    check_eq("misalign_err", 32'(obs_mis), 32'd1);
    reqs_seen = (obs_req ? 1 : 0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (obs_req) reqs_seen++;
    end
    check_eq("misalign_noreq", 32'(reqs_seen), 32'd0);
`else
    reqs_seen = 0;
    repeat (8) cycle();
    check_eq("unaligned_mis", 32'(obs_mis), 32'd0);
    check_eq("unaligned_grants", 32'(grant_q.size() >= 1), 32'd1);
    if (grant_q.size() >= 1) check_eq("unaligned_addr", grant_q[0], 32'h100);
    if (pop_pc_q.size() >= 1) check_eq("unaligned_pc", pop_pc_q[0], 32'h100);
    else check_eq("unaligned_pops", 32'(pop_pc_q.size()), 32'd1);
`endif

    // High RESET_PC wraps through zero
    do_reset();
    repeat (10) cycle();
    check_eq("wrap_pops", 32'(pop_pc_b.size() >= 3), 32'd1);
    if (pop_pc_b.size() >= 3) begin
      check_eq("wrap_pc0",   pop_pc_b[0], 32'hFFFF_FFF8);
      check_eq("wrap_pc1",   pop_pc_b[1], 32'hFFFF_FFFC);
      check_eq("wrap_pc2",   pop_pc_b[2], 32'h0000_0000);
      check_eq("wrap_word2", pop_word_b[2], 32'hFFFF_FFFF);
    end

    // Reset while a request is outstanding; late response must be ignored
    do_reset();
    cycle();
    check_eq("wait_pending", 32'(pend_a), 32'd1);
    rst = 1'b1; rv_hold = 1'b1;
    cycle();
    check_eq("rstwait_req",   32'(obs_req), 32'd0);
    check_eq("rstwait_valid", 32'(obs_valid), 32'd0);
    rst = 1'b0; rv_hold = 1'b0; gnt_en = 1'b0;
    cycle();
    check_eq("late_rv_req", 32'(obs_req), 32'd1);
    cycle();
    check_eq("late_rv_valid", 32'(obs_valid), 32'd0);
    clear_logs();
    gnt_en = 1'b1;
    repeat (6) cycle();
    check_eq("post_rst_pops", 32'(pop_pc_q.size() >= 1), 32'd1);
    if (pop_pc_q.size() >= 1) check_eq("post_rst_pc0", pop_pc_q[0], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
